fp32_acc: RTL and testbench

FP32_ACC -- requirements
Module: fp32_acc

---
 rtl/fp32_acc.sv | 154 +++++++++++++++
 tb/tb_fp32_acc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_acc.sv
// rtl/fp32_acc.sv - FP32 accumulator summing LEN products with truncation, sticky overflow and ready/valid handshakes
module fp32_acc #(
    parameter int LEN   = 16,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_overflow,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sticky_q;
    logic [23:0]        big_mant_q, small_mant_q;
    logic [7:0]         big_exp_q;
    logic               sign_q, sub_q, inf_q;
    logic [24:0]        sum_q;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    // Operand decode: zero and denormals both use exponent 1 with hidden bit 0
    logic [7:0]  a_exp, b_exp, exp_diff;
    logic [23:0] a_mant, b_mant, big_mant, small_mant, small_shift;
    logic [7:0]  big_exp;
    logic        a_big, big_sign;

    always_comb begin
        a_exp       = (acc_q[30:23] == 8'd0) ? 8'd1 : acc_q[30:23];
        b_exp       = (op_q[30:23] == 8'd0) ? 8'd1 : op_q[30:23];
        a_mant      = {|acc_q[30:23], acc_q[22:0]};
        b_mant      = {|op_q[30:23], op_q[22:0]};
        a_big       = {a_exp, a_mant} >= {b_exp, b_mant};
        big_mant    = a_big ? a_mant : b_mant;
        small_mant  = a_big ? b_mant : a_mant;
        big_exp     = a_big ? a_exp : b_exp;
        big_sign    = a_big ? acc_q[31] : op_q[31];
        exp_diff    = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
        small_shift = (exp_diff >= 8'd25) ? 24'd0 : (small_mant >> exp_diff);
    end

    // Normalisation; left shift is capped so the exponent never drops below 1
    logic [4:0]  lz, sh;
    logic [7:0]  max_sh;
    logic [23:0] n_mant;
    logic [8:0]  n_exp;
    logic [31:0] res;
    logic        res_ovf;

    always_comb begin
        lz      = lzc24(sum_q[23:0]);
        max_sh  = big_exp_q - 8'd1;
        sh      = ({3'b000, lz} > max_sh) ? max_sh[4:0] : lz;
        n_mant  = sum_q[23:0] << sh;
        n_exp   = {1'b0, big_exp_q} - {4'b0000, sh};
        res     = 32'd0;
        res_ovf = 1'b0;
        if (sum_q[24]) begin
            n_mant = sum_q[24:1];
            n_exp  = {1'b0, big_exp_q} + 9'd1;
        end
        if (inf_q) begin
            res     = {op_q[31], 8'hFF, 23'd0};
            res_ovf = 1'b1;
        end else if (n_exp >= 9'd255) begin
            res     = {sign_q, 8'hFF, 23'd0};
            res_ovf = 1'b1;
        end else if (n_mant != 24'd0) begin
            res = {sign_q, (n_mant[23] ? n_exp[7:0] : 8'd0), n_mant[22:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = (cnt_q == CNT_W'(LEN)) ? OUT : IDLE;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= 32'd0;
            op_q         <= 32'd0;
            cnt_q        <= '0;
            sticky_q     <= 1'b0;
            big_mant_q   <= 24'd0;
            small_mant_q <= 24'd0;
            big_exp_q    <= 8'd1;
            sign_q       <= 1'b0;
            sub_q        <= 1'b0;
            inf_q        <= 1'b0;
            sum_q        <= 25'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q     <= in_data;
                    sticky_q <= sticky_q | in_ovf;
                    cnt_q    <= cnt_q + CNT_W'(1);
                end
                ALIGN: begin
                    big_mant_q   <= big_mant;
                    small_mant_q <= small_shift;
                    big_exp_q    <= big_exp;
                    sign_q       <= big_sign;
                    sub_q        <= acc_q[31] ^ op_q[31];
                    inf_q        <= op_q[30:23] == 8'hFF;
                end
                ADD: sum_q <= sub_q ? ({1'b0, big_mant_q} - {1'b0, small_mant_q})
                                    : ({1'b0, big_mant_q} + {1'b0, small_mant_q});
                NORM: if (!sticky_q) begin
                    acc_q <= res;
                    if (res_ovf) sticky_q <= 1'b1;
                end
                OUT: if (out_ready) begin
                    acc_q    <= 32'd0;
                    cnt_q    <= '0;
                    sticky_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = state_q == IDLE;
    assign out_valid    = state_q == OUT;
    assign busy         = state_q != IDLE;
    assign out_data     = acc_q;
    assign out_overflow = sticky_q;

endmodule

// File: tb/tb_fp32_acc.sv
// tb/tb_fp32_acc.sv - directed self-checking bench for fp32_acc at LEN=4, 2 and 1
module tb_fp32_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  iv = 3'b000;
    logic [31:0] in_data = 32'd0;
    logic        in_ovf = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  irdy, ovld, oovf, bsy;
    logic [31:0] od [3];
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    fp32_acc #(.LEN(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(in_data),
        .in_ovf(in_ovf), .out_valid(ovld[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_overflow(oovf[0]), .busy(bsy[0])
    );
    fp32_acc #(.LEN(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(in_data),
        .in_ovf(in_ovf), .out_valid(ovld[1]), .out_ready(out_ready), .out_data(od[1]),
        .out_overflow(oovf[1]), .busy(bsy[1])
    );
    fp32_acc #(.LEN(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(in_data),
        .in_ovf(in_ovf), .out_valid(ovld[2]), .out_ready(out_ready), .out_data(od[2]),
        .out_overflow(oovf[2]), .busy(bsy[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [31:0] d, input logic ovf);
        int n = 0;
        while (irdy[k] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("push_ready", {31'd0, irdy[k]}, 32'd1);
        in_data = d;
        in_ovf  = ovf;
        iv[k]   = 1'b1;
        step();
        iv     = 3'b000;
        in_ovf = 1'b0;
    endtask

    task automatic wait_valid(input int k);
        int n = 0;
        while (ovld[k] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("out_valid_seen", {31'd0, ovld[k]}, 32'd1);
    endtask

    task automatic wait_out(input int k, input string tag, input logic [31:0] d, input logic ovf);
        wait_valid(k);
        check(tag, od[k], d);
        check({tag, "_ovf"}, {31'd0, oovf[k]}, {31'd0, ovf});
        step();
    endtask

    task automatic check_reset(input int k, input string tag);
        check({tag, "_in_ready"}, {31'd0, irdy[k]}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, ovld[k]}, 32'd0);
        check({tag, "_out_data"}, od[k], 32'd0);
        check({tag, "_out_ovf"}, {31'd0, oovf[k]}, 32'd0);
        check({tag, "_busy"}, {31'd0, bsy[k]}, 32'd0);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check_reset(0, "rst");
        rst = 1'b0;
        step();

        // 1+2+3+4 with exact cycle timing around the last transfer
        push(0, 32'h3F800000, 1'b0);
        push(0, 32'h40000000, 1'b0);
        check("r18_busy", {31'd0, irdy[0]}, 32'd0);
        repeat (3) step();
        check("r18_ready_t4", {31'd0, irdy[0]}, 32'd1);
        check("partial_sum", od[0], 32'h40400000);
        push(0, 32'h40400000, 1'b0);
        push(0, 32'h40800000, 1'b0);
        check("last_ready0_a", {31'd0, irdy[0]}, 32'd0);
        check("last_valid0_a", {31'd0, ovld[0]}, 32'd0);
        step();
        check("last_valid0_b", {31'd0, ovld[0]}, 32'd0);
        step();
        check("last_valid0_c", {31'd0, ovld[0]}, 32'd0);
        step();
        check("sum4_valid", {31'd0, ovld[0]}, 32'd1);
        check("sum4_data", od[0], 32'h41200000);
        check("sum4_ovf", {31'd0, oovf[0]}, 32'd0);
        step();
        check("sum4_clr_valid", {31'd0, ovld[0]}, 32'd0);
        check("sum4_clr_data", od[0], 32'd0);

        push(1, 32'h3FC00000, 1'b0);
        push(1, 32'hBFC00000, 1'b0);
        wait_out(1, "cancel", 32'h00000000, 1'b0);

        push(1, 32'h3F800000, 1'b0);
        push(1, 32'h33800000, 1'b0);
        wait_out(1, "trunc", 32'h3F800000, 1'b0);

        push(1, 32'h7F7FFFFF, 1'b0);
        push(1, 32'h7F7FFFFF, 1'b0);
        wait_out(1, "ovf_sum", 32'h7F800000, 1'b1);
        check("ovf_cleared", {31'd0, oovf[1]}, 32'd0);
        push(1, 32'h40000000, 1'b0);
        repeat (3) step();
        check("next_first_ovf", {31'd0, oovf[1]}, 32'd0);
        check("next_first_data", od[1], 32'h40000000);
        push(1, 32'h3F800000, 1'b0);
        wait_out(1, "next_sum", 32'h40400000, 1'b0);

        push(1, 32'h3F800000, 1'b0);
        push(1, 32'hBF400000, 1'b0);
        wait_out(1, "sub_norm", 32'h3E800000, 1'b0);

        push(1, 32'h00000001, 1'b0);
        push(1, 32'h00000001, 1'b0);
        wait_out(1, "denorm", 32'h00000002, 1'b0);

        // Overflow flag from the multiplier freezes the accumulator
        push(2, 32'h40000000, 1'b1);
        wait_out(2, "in_ovf_hold", 32'h00000000, 1'b1);

        out_ready = 1'b0;
        push(2, 32'h3F800000, 1'b0);
        wait_valid(2);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, ovld[2]}, 32'd1);
            check("bp_data", od[2], 32'h3F800000);
            check("bp_ready", {31'd0, irdy[2]}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_clr_valid", {31'd0, ovld[2]}, 32'd0);
        check("bp_clr_data", od[2], 32'd0);
        push(2, 32'h40000000, 1'b0);
        wait_out(2, "after_bp", 32'h40000000, 1'b0);

        // Reset while the second element is in ADD
        push(1, 32'h3F800000, 1'b0);
        push(1, 32'h40000000, 1'b0);
        step();
        rst = 1'b1;
        step();
        check_reset(1, "midrst");
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (ovld[1] === 1'b1) seen++;
            step();
        end
        check("midrst_no_valid", seen, 32'd0);
        push(1, 32'h40400000, 1'b0);
        push(1, 32'h40800000, 1'b0);
        wait_out(1, "after_rst", 32'h40E00000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
